// File: rtl/srl_pkg.sv
// Shared defaults and the address-width helper for the RAM-based shift register.
package srl_pkg;

  localparam int DSIZE_DEF  = 16;
  localparam int WDEPTH_DEF = 640;

  function automatic int srl_asize(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/srl_sdp_ram.sv
// DSIZE x WDEPTH synchronous RAM, one shared address, registered read with
// read-old-data behaviour on a same-address read/write (maps to block RAM).
import srl_pkg::*;

module srl_sdp_ram #(
  parameter int DSIZE  = DSIZE_DEF,
  parameter int WDEPTH = WDEPTH_DEF,
  parameter int ASIZE  = srl_asize(WDEPTH_DEF)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [ASIZE-1:0] addr,
  input  logic [DSIZE-1:0] wdata,
  output logic [DSIZE-1:0] rdata
);

  logic [DSIZE-1:0] mem [WDEPTH];

  // NOTE: the array and read register take no reset; resetting them would
  // stop the tools from mapping this onto block RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      // NOTE: non-blocking assignments make the read see the pre-write word.
      rdata     <= mem[addr];
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/ram_based_shift_reg_top.sv
// Fixed-length delay line on a circular block-RAM buffer: Q = Din delayed by
// WDEPTH shifts, forced to 0 until the buffer is primed. Optional SRL_CE_EN adds ce.
import srl_pkg::*;

module ram_based_shift_reg_top #(
  parameter int DSIZE  = DSIZE_DEF,
  parameter int WDEPTH = WDEPTH_DEF
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [DSIZE-1:0] Din,
`ifdef SRL_CE_EN
  input  logic             ce,
`endif
  output logic [DSIZE-1:0] Q
);

  localparam int               ASIZE = srl_asize(WDEPTH);
  localparam logic [ASIZE-1:0] LAST  = ASIZE'(WDEPTH - 1);
  localparam logic [ASIZE:0]   FULL  = (ASIZE + 1)'(WDEPTH);

  logic             en;
  logic [ASIZE-1:0] wr_ptr;
  logic [ASIZE:0]   fill;
  logic             primed;
  logic [DSIZE-1:0] rd_data;

`ifdef SRL_CE_EN
  assign en = ce;
`else
  assign en = 1'b1;
`endif

  // primed rises on the shift whose read returns the first post-reset sample.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      fill   <= '0;
      primed <= 1'b0;
    end else if (en) begin
      wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (fill != FULL) begin
        fill <= fill + 1'b1;
      end
      primed <= (fill == FULL);
    end
  end

  srl_sdp_ram #(
    .DSIZE  (DSIZE),
    .WDEPTH (WDEPTH),
    .ASIZE  (ASIZE)
  ) u_ram (
    .clk   (clk),
    .en    (en),
    .addr  (wr_ptr),
    .wdata (Din),
    .rdata (rd_data)
  );

  // Both terms are registers; the gate clears Q asynchronously and hides stale RAM.
  assign Q = primed ? rd_data : '0;

endmodule

// File: tb/tb_ram_based_shift_reg_top.sv
// Directed bench for ram_based_shift_reg_top at depths 640, 2 and 5, with a
// ce-toggling phase when SRL_CE_EN is defined.
module tb_ram_based_shift_reg_top;

  logic        clk = 1'b0;
  logic        Reset;
  logic [15:0] din;
  logic        ce;
  logic [15:0] q640, q2, q5;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] hist [$];

  always #5 clk = ~clk;

  ram_based_shift_reg_top #(.DSIZE(16), .WDEPTH(640)) dut640 (
    .clk(clk), .Reset(Reset), .Din(din),
`ifdef SRL_CE_EN
    .ce(ce),
`endif
    .Q(q640));

  ram_based_shift_reg_top #(.DSIZE(16), .WDEPTH(2)) dut2 (
    .clk(clk), .Reset(Reset), .Din(din),
`ifdef SRL_CE_EN
    .ce(ce),
`endif
    .Q(q2));

  ram_based_shift_reg_top #(.DSIZE(16), .WDEPTH(5)) dut5 (
    .clk(clk), .Reset(Reset), .Din(din),
`ifdef SRL_CE_EN
    .ce(ce),
`endif
    .Q(q5));

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sample accepted d shifts ago, or 0 while fewer than d+1 shifts have happened.
  function automatic logic [15:0] model(input int d);
    int n = hist.size();
    return (n > d) ? hist[n - 1 - d] : 16'd0;
  endfunction

  // Counter run from 0 after reset: Q = din - (d+1) once primed.
  function automatic logic [15:0] counter_exp(input int d);
    int c = int'(din);
    return (c >= d + 1) ? 16'(c - d - 1) : 16'd0;
  endfunction

  task automatic tick();
    if (ce) hist.push_back(din);
    @(posedge clk);
    #1;
  endtask

  task automatic check_models(input string ph);
    check({ph, "_d640"}, q640, model(640));
    check({ph, "_d2"},   q2,   model(2));
    check({ph, "_d5"},   q5,   model(5));
  endtask

  task automatic count_cycles(input int n, input string ph);
    for (int i = 0; i < n; i++) begin
      tick();
      din = din + 16'd1;
      check_models(ph);
      check({ph, "_cnt640"}, q640, counter_exp(640));
      check({ph, "_cnt2"},   q2,   counter_exp(2));
      check({ph, "_cnt5"},   q5,   counter_exp(5));
    end
  endtask

  // Called just after a posedge; Reset low for 100 time units, released mid-cycle.
  task automatic pulse_reset(input string ph);
    Reset = 1'b0;
    #1;
    check({ph, "_async640"}, q640, 16'd0);
    check({ph, "_async2"},   q2,   16'd0);
    check({ph, "_async5"},   q5,   16'd0);
    #99;
    check({ph, "_held640"}, q640, 16'd0);
    check({ph, "_held5"},   q5,   16'd0);
    hist.delete();
    din   = 16'd0;
    Reset = 1'b1;
  endtask

  initial begin
    Reset = 1'b0;
    din   = 16'd0;
    ce    = 1'b1;

    repeat (10) @(posedge clk);
    #1;
    check("reset_q640", q640, 16'd0);
    check("reset_q2",   q2,   16'd0);
    check("reset_q5",   q5,   16'd0);
    Reset = 1'b1;

    // Prime and run past the first wrap of the 640-deep buffer.
    count_cycles(700, "prime");
    check("pre_reset_nonzero", q640, 16'd59);

    // Mid-run reset: nothing from before it may reappear.
    pulse_reset("midrst");
    count_cycles(5000, "steady");

    for (int i = 0; i < 2000; i++) begin
      tick();
      din = 16'($urandom);
      check_models("rand");
    end

`ifdef SRL_CE_EN
    // ce alternates 1,0,1,0: only enabled edges shift and count toward latency.
    pulse_reset("ce_rst");
    for (int i = 0; i < 1400; i++) begin
      ce = (i % 2 == 0);
      tick();
      din = din + 16'd1;
      check_models("ce");
    end
    ce = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
